// File: rtl/regfile_dump.sv
// Walks an 8-entry register file through one async read port and streams each value as a valid/ready beat.
// Optional macro REGDUMP_HEADER_EN prepends a fixed 8'hA5 header beat to every dump.
module regfile_dump #(
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic        [ADDR_W-1:0] rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic        [ADDR_W-1:0] m_index,
    output logic                     m_last,
    output logic                     done
);

`ifdef REGDUMP_HEADER_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_SEND, S_DONE} state_t;
    localparam logic signed [DATA_W-1:0] HDR_BYTE = DATA_W'(8'hA5);
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    state_t                     state_q, state_d;
    logic        [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic signed [DATA_W-1:0]   data_q, data_d;
    logic        [ADDR_W-1:0]   index_q, index_d;
    logic                       last_q, last_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        data_d    = data_q;
        index_d   = index_q;
        last_d    = last_q;
        unique case (state_q)
            S_IDLE: begin
                rd_addr_d = '0;
                if (start) begin
`ifdef REGDUMP_HEADER_EN
                    state_d = S_HDR;
                    data_d  = HDR_BYTE;
                    index_d = '0;
                    last_d  = 1'b0;
`else
                    state_d = S_LOAD;
`endif
                end
            end
`ifdef REGDUMP_HEADER_EN
            S_HDR: begin
                if (m_ready) begin
                    state_d   = S_LOAD;
                    rd_addr_d = '0;
                end
            end
`endif
            // Snapshot point: the register is sampled in its own LOAD cycle.
            S_LOAD: begin
                data_d  = rd_data;
                index_d = rd_addr_q;
                last_d  = (rd_addr_q == LAST_ADDR);
                state_d = S_SEND;
            end
            S_SEND: begin
                if (m_ready) begin
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                rd_addr_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are glitch-free.
    always_comb begin
        valid_d = (state_d == S_SEND);
`ifdef REGDUMP_HEADER_EN
        if (state_d == S_HDR) valid_d = 1'b1;
`endif
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            data_q    <= '0;
            index_q   <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            data_q    <= data_d;
            index_q   <= index_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign m_data  = data_q;
    assign m_index = index_q;
    assign m_last  = last_q;
    assign m_valid = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump; define REGDUMP_HEADER_EN to exercise the header-beat build.
module tb_regfile_dump;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [2:0] m_index;
    logic       m_last;
    logic       done;

    logic [7:0] regs [8];
    logic [7:0] pre  [8];

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int done_cnt = 0;

`ifdef REGDUMP_HEADER_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    regfile_dump dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_index (m_index),
        .m_last  (m_last),
        .done    (done)
    );

    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && m_valid && m_ready) hs_cnt <= hs_cnt + 1;
        if (!reset && done) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload;
        for (int i = 0; i < 8; i++) regs[i] = pre[i];
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!m_valid && n < bound) begin
            tick;
            n++;
        end
        check("wait_valid", m_valid, 1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick;
            n++;
        end
        check("wait_done", done, 1);
    endtask

    // Called in an IDLE cycle with m_ready high; wr plants reg5 writes after beats 2 and 6.
    task automatic fast_dump(input string tag, input bit wr);
        logic [7:0] e;
        start = 1'b1;
        tick;
        start = 1'b0;
        check({tag, "_busy_n1"}, busy, 1);
`ifdef REGDUMP_HEADER_EN
        check({tag, "_hdr_valid"}, m_valid, 1);
        check({tag, "_hdr_data"}, m_data, 8'hA5);
        check({tag, "_hdr_index"}, m_index, 0);
        check({tag, "_hdr_last"}, m_last, 0);
        tick;
`endif
        check({tag, "_load0_valid"}, m_valid, 0);
        for (int i = 0; i < 8; i++) begin
            e = (wr && i == 5) ? 8'h3C : pre[i];
            tick;
            check({tag, "_beat_valid"}, m_valid, 1);
            check({tag, "_beat_data"}, m_data, e);
            check({tag, "_beat_index"}, m_index, i);
            check({tag, "_beat_last"}, m_last, (i == 7));
            check({tag, "_beat_nodone"}, done, 0);
            tick;
            if (wr && i == 2) regs[5] = 8'h3C;
            if (wr && i == 6) regs[5] = 8'h99;
            if (i < 7) check({tag, "_load_valid"}, m_valid, 0);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_done_busy"}, busy, 1);
        tick;
        check({tag, "_after_done"}, done, 0);
        check({tag, "_after_busy"}, busy, 0);
    endtask

    task automatic stall_beat(input logic [7:0] ed, input logic [2:0] ei, input logic el);
        wait_valid(8);
        check("stall_data_c0", m_data, ed);
        check("stall_index_c0", m_index, ei);
        check("stall_last_c0", m_last, el);
        for (int c = 1; c < 4; c++) begin
            tick;
            check("stall_valid_held", m_valid, 1);
            check("stall_data_held", m_data, ed);
            check("stall_index_held", m_index, ei);
        end
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
    endtask

    initial begin
        int h0;
        int d0;
        int n;
        pre = '{8'h10, 8'hF3, 8'h7F, 8'h80, 8'h00, 8'h55, 8'hAA, 8'hFF};
        preload();

        // Reset state
        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_index", m_index, 0);
        check("rst_last", m_last, 0);
        check("rst_done", done, 0);
        check("rst_addr", rd_addr, 0);
        reset = 1'b0;
        tick;

        // Full-rate dump
        m_ready = 1'b1;
        fast_dump("fast", 1'b0);

        // Writes around snapshot points
        tick;
        fast_dump("snap", 1'b1);
        preload();

        // Stalled dump
        m_ready = 1'b0;
        tick;
        h0 = hs_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
`ifdef REGDUMP_HEADER_EN
        stall_beat(8'hA5, 3'd0, 1'b0);
`endif
        for (int i = 0; i < 8; i++) stall_beat(pre[i], 3'(i), (i == 7));
        wait_done(4);
        tick;
        check("stall_handshakes", hs_cnt - h0, NB);

        // start held high while busy
        m_ready = 1'b1;
        tick;
        d0 = done_cnt;
        start = 1'b1;
        tick;
        wait_done(30);
        tick;
        check("hold_busy_done1", busy, 0);
        check("hold_one_done", done_cnt - d0, 1);
        tick;
        start = 1'b0;
        check("restart_busy", busy, 1);
        wait_done(30);
        tick;
        check("restart_done_cnt", done_cnt - d0, 2);

        // Reset mid-dump while stalled on index 4
        tick;
        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (!(m_valid && m_index == 3'd4) && n < 40) begin
            tick;
            n++;
        end
        m_ready = 1'b0;
        check("mid_found_idx4", m_index, 4);
        tick;
        check("mid_stall_valid", m_valid, 1);
        check("mid_stall_data", m_data, pre[4]);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_index", m_index, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_addr", rd_addr, 0);
        tick;
        tick;
        tick;
        check("mid_no_done", done_cnt - d0, 0);
        m_ready = 1'b1;
        fast_dump("post_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
